// File: rtl/argmax_sequencer_if.sv
// argmax_sequencer_if: frame control, score stream and result handshake bundle
interface argmax_sequencer_if #(
   parameter int DATA_W = 46,
   parameter int IDX_W  = 5
);
   logic                     start;
   logic                     abort;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic        [IDX_W-1:0]  numbers;
   logic signed [DATA_W-1:0] max_score;
   logic                     busy;

   modport master (
      output start, abort, in_valid, in_data, out_ready,
      input  in_ready, out_valid, numbers, max_score, busy
   );

   modport slave (
      input  start, abort, in_valid, in_data, out_ready,
      output in_ready, out_valid, numbers, max_score, busy
   );
endinterface

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: streams NUM_CLASSES signed scores per frame and reports the first index of the maximum
module argmax_sequencer #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 46,
   parameter int IDX_W       = 5
) (
   input logic                clk,
   input logic                rst_n,
   argmax_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

   state_t                   state_q, state_d;
   logic        [IDX_W-1:0]  cnt_q, cnt_d;
   logic        [IDX_W-1:0]  idx_q, idx_d;
   logic signed [DATA_W-1:0] max_q, max_d;
   logic        [IDX_W-1:0]  num_q, num_d;
   logic signed [DATA_W-1:0] score_q, score_d;

   // Handshake outputs come straight from the state register
   assign bus.in_ready  = state_q == ACCUM;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy      = state_q != IDLE;
   assign bus.numbers   = num_q;
   assign bus.max_score = score_q;

   // Next state, running max tracking and result capture; abort overrides everything but the held result
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      max_d   = max_q;
      num_d   = num_q;
      score_d = score_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = ACCUM;
            cnt_d   = '0;
         end
         ACCUM: if (bus.in_valid) begin
            if (cnt_q == '0 || bus.in_data > max_q) begin
               max_d = bus.in_data;
               idx_d = cnt_q;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               num_d   = idx_d;
               score_d = max_d;
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = idx_q;
         max_d   = max_q;
         num_d   = num_q;
         score_d = score_q;
      end
   end

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         num_q   <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
         num_q   <= num_d;
         score_q <= score_d;
      end
   end
endmodule

// File: tb/tb_argmax_sequencer.sv
// tb_argmax_sequencer: directed frames with hand-computed argmax results
module tb_argmax_sequencer;
   localparam int DW = 46;
   localparam int IW = 5;
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total = 0;
   logic signed [DW-1:0] sc [10];

   always #5 clk = ~clk;

   argmax_sequencer_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

   argmax_sequencer #(.NUM_CLASSES(10), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic feed(input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) begin
            bus.in_valid = 1'b0;
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = sc[i];
         tick();
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic take_result;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.numbers !== 5'd0) $display("FAIL rst_numbers got %0d want 0", bus.numbers); else passed++;
      total++; if (bus.max_score !== 46'sd0) $display("FAIL rst_max_score got %0d want 0", bus.max_score); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ascending;
      sc = '{46'sd10, 46'sd20, 46'sd30, 46'sd40, 46'sd50, 46'sd60, 46'sd70, 46'sd80, 46'sd90, 46'sd100};
      do_start();
      total++; if (bus.in_ready !== 1'b1) $display("FAIL asc_in_ready got %b want 1", bus.in_ready); else passed++;
      feed(0, 8, 1'b0);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL asc_early_valid got %b want 0", bus.out_valid); else passed++;
      feed(9, 9, 1'b0);
      total++; if (bus.out_valid !== 1'b1) $display("FAIL asc_latency got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL asc_done_in_ready got %b want 0", bus.in_ready); else passed++;
      total++; if (bus.numbers !== 5'd9) $display("FAIL asc_numbers got %0d want 9", bus.numbers); else passed++;
      total++; if (bus.max_score !== 46'sd100) $display("FAIL asc_max_score got %0d want 100", bus.max_score); else passed++;
      take_result();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL asc_released got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL asc_idle_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.numbers !== 5'd9) $display("FAIL asc_hold_numbers got %0d want 9", bus.numbers); else passed++;
   endtask

   task automatic test_tie;
      for (int i = 0; i < 10; i++) sc[i] = -46'sd5;
      do_start();
      feed(0, 9, 1'b0);
      total++; if (bus.numbers !== 5'd0) $display("FAIL tie_numbers got %0d want 0", bus.numbers); else passed++;
      total++; if (bus.max_score !== -46'sd5) $display("FAIL tie_max_score got %0d want -5", bus.max_score); else passed++;
      take_result();
   endtask

   task automatic test_signed;
      for (int i = 0; i < 10; i++) sc[i] = MINV;
      sc[3] = MINV + 46'sd1;
      do_start();
      feed(0, 9, 1'b0);
      total++; if (bus.numbers !== 5'd3) $display("FAIL sgn_numbers got %0d want 3", bus.numbers); else passed++;
      total++; if (bus.max_score !== MINV + 46'sd1) $display("FAIL sgn_max_score got %0d want %0d", bus.max_score, MINV + 46'sd1); else passed++;
      take_result();
   endtask

   task automatic test_stall_done_hold;
      sc = '{46'sd3, -46'sd7, 46'sd42, 46'sd42, 46'sd0, -46'sd1, 46'sd41, 46'sd42, 46'sd5, 46'sd6};
      do_start();
      feed(0, 4, 1'b1);
      repeat (4) tick();
      total++; if (bus.in_ready !== 1'b1) $display("FAIL stall_in_ready got %b want 1", bus.in_ready); else passed++;
      feed(5, 9, 1'b1);
      for (int c = 0; c < 5; c++) begin
         bus.start = (c % 2 == 0);
         tick();
         total++; if (bus.out_valid !== 1'b1) $display("FAIL hold_valid_%0d got %b want 1", c, bus.out_valid); else passed++;
         total++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready_%0d got %b want 0", c, bus.in_ready); else passed++;
         total++; if (bus.numbers !== 5'd2) $display("FAIL hold_numbers_%0d got %0d want 2", c, bus.numbers); else passed++;
         total++; if (bus.max_score !== 46'sd42) $display("FAIL hold_score_%0d got %0d want 42", c, bus.max_score); else passed++;
      end
      bus.start = 1'b1;
      take_result();
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL restart_busy got %b want 0", bus.busy); else passed++;
      tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL restart_idle got %b want 0", bus.busy); else passed++;
   endtask

   task automatic test_abort;
      for (int i = 0; i < 10; i++) sc[i] = 46'sd900;
      do_start();
      feed(0, 3, 1'b0);
      total++; if (bus.numbers !== 5'd2) $display("FAIL abort_prev_numbers got %0d want 2", bus.numbers); else passed++;
      total++; if (bus.max_score !== 46'sd42) $display("FAIL abort_prev_score got %0d want 42", bus.max_score); else passed++;
      bus.abort    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 46'sd900;
      tick();
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready got %b want 0", bus.in_ready); else passed++;
      total++; if (bus.max_score !== 46'sd42) $display("FAIL abort_held_score got %0d want 42", bus.max_score); else passed++;
      sc = '{46'sd1, 46'sd2, 46'sd3, 46'sd4, 46'sd5, 46'sd6, 46'sd7, 46'sd500, 46'sd499, 46'sd500};
      do_start();
      feed(0, 9, 1'b0);
      total++; if (bus.numbers !== 5'd7) $display("FAIL abort_new_numbers got %0d want 7", bus.numbers); else passed++;
      total++; if (bus.max_score !== 46'sd500) $display("FAIL abort_new_score got %0d want 500", bus.max_score); else passed++;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL abort_done_valid got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.numbers !== 5'd7) $display("FAIL abort_done_numbers got %0d want 7", bus.numbers); else passed++;
   endtask

   task automatic test_reset_midframe;
      for (int i = 0; i < 10; i++) sc[i] = 46'sd1000;
      do_start();
      feed(0, 5, 1'b0);
      rst_n = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got %b want 0", bus.in_ready); else passed++;
      total++; if (bus.numbers !== 5'd0) $display("FAIL mid_rst_numbers got %0d want 0", bus.numbers); else passed++;
      total++; if (bus.max_score !== 46'sd0) $display("FAIL mid_rst_score got %0d want 0", bus.max_score); else passed++;
      #2;
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 46'sd999;
      tick();
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL mid_needs_start got %b want 0", bus.busy); else passed++;
      sc = '{-46'sd10, -46'sd3, -46'sd8, -46'sd3, -46'sd20, -46'sd4, -46'sd3, -46'sd9, -46'sd50, -46'sd11};
      do_start();
      feed(0, 9, 1'b1);
      total++; if (bus.out_valid !== 1'b1) $display("FAIL mid_new_valid got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.numbers !== 5'd1) $display("FAIL mid_new_numbers got %0d want 1", bus.numbers); else passed++;
      total++; if (bus.max_score !== -46'sd3) $display("FAIL mid_new_score got %0d want -3", bus.max_score); else passed++;
      take_result();
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_ascending();
      test_tie();
      test_signed();
      test_stall_done_hold();
      test_abort();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/argmax_sequencer.md
ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, number of score beats per frame.
REQ-002 The block SHALL have parameter DATA_W, default 46, signed score width.
REQ-003 The block SHALL have parameter IDX_W, default 5, class index width; NUM_CLASSES <= 2^IDX_W.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, begins a frame; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1, synchronous frame cancel.
REQ-008 The block SHALL have port in_valid, input, 1, score beat valid.
REQ-009 The block SHALL have port in_ready, output, 1, block accepts a score beat.
REQ-010 The block SHALL have port in_data, input, DATA_W, signed score, two's complement.
REQ-011 The block SHALL have port out_valid, output, 1, result available.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 The block SHALL have port numbers, output, IDX_W, winning class index.
REQ-014 The block SHALL have port max_score, output, DATA_W, winning score, signed.
REQ-015 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ACCUM and DONE.
REQ-017 In IDLE: in_ready=0 and out_valid=0; start=1 -> ACCUM next cycle, beat counter cleared to 0.
REQ-018 In ACCUM: in_ready=1; a beat is accepted when in_valid&in_ready on a rising edge.
REQ-019 On an accepted beat with count==0, the block SHALL load running max=in_data and running index=0 unconditionally.
REQ-020 On an accepted beat with count>0, the block SHALL update running max/index only when in_data > running max under a signed DATA_W comparison.
REQ-021 Ties SHALL keep the earlier index: the lowest index of the maximum value wins.
REQ-022 After each accepted beat the counter SHALL increment by 1; on the beat with count==NUM_CLASSES-1, the next state SHALL be DONE and the counter SHALL clear.
REQ-023 in_valid=0 cycles in ACCUM SHALL stall with no state change and no time limit.
REQ-024 On entering DONE, numbers and max_score SHALL take the final running index/max; out_valid SHALL rise the cycle after the last beat is accepted (latency 1).
REQ-025 In DONE: in_ready=0, out_valid=1, numbers/max_score stable; out_ready=1 -> IDLE next cycle.
REQ-026 numbers and max_score SHALL hold the last result outside DONE until the next frame completes.
REQ-027 start SHALL be ignored in ACCUM and DONE, including start coincident with out_ready in DONE (no back-to-back restart; the next start is sampled in IDLE).
REQ-028 abort=1 in any state SHALL force IDLE next cycle, clear the counter, drop out_valid and leave numbers/max_score unchanged.
REQ-029 abort SHALL have priority over start, beat acceptance and out_ready on the same edge; a beat presented with abort=1 is not accumulated.
REQ-030 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously force IDLE, counter=0, running max/index=0, numbers=0, max_score=0, out_valid=0, in_ready=0, busy=0.
REQ-032 Reset mid-frame SHALL discard partial results; the first frame after reset release requires a new start.

Verification
REQ-033 Ascending scores 10,20,...,100 -> numbers=9, max_score=100, out_valid exactly 1 cycle after the 10th beat is accepted.
REQ-034 All ten scores=-5 -> numbers=0, max_score=-5 (tie rule).
REQ-035 All scores=-2^45 except index 3=-2^45+1 -> numbers=3 (signed compare, first-beat load).
REQ-036 Random in_valid gaps, out_ready low for 5 cycles in DONE, start pulsed in DONE -> numbers/max_score/out_valid stable, in_ready=0, start ignored, IDLE after out_ready.
REQ-037 abort after 4 beats, then a new frame with maximum 500 at index 7 -> numbers=7, max_score=500; previous result held during the aborted frame.
REQ-038 rst_n low after 6 beats -> all outputs 0 immediately; a subsequent full frame produces the correct result.
